// File: rtl/ds_serializer.sv
// Wide-to-narrow serializer: one prefetch register feeds a shift stage that emits RATIO beats per word.
// Define DS_SERIALIZER_MSB_FIRST_EN to emit the most-significant slice first (default: LSB slice first).
module ds_serializer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH*RATIO-1:0]   i_dat,
    input  logic                     i_val,
    output logic                     i_rdy,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_val,
    output logic                     o_last,
    input  logic                     o_rdy
);

    localparam int WW = WIDTH * RATIO;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    logic [WW-1:0] in_reg_q, in_reg_d;
    logic          in_val_q, in_val_d;
    logic [WW-1:0] sh_reg_q, sh_reg_d;
    logic          sh_val_q, sh_val_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;
    logic          adv;
    logic [CW-1:0] sel;

    assign at_last = (cnt_q == CNT_LAST);
    assign adv     = ~sh_val_q | (o_rdy & at_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_reg_q <= '0;
            in_val_q <= 1'b0;
            sh_reg_q <= '0;
            sh_val_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            in_reg_q <= in_reg_d;
            in_val_q <= in_val_d;
            sh_reg_q <= sh_reg_d;
            sh_val_q <= sh_val_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        in_reg_d = in_reg_q;
        in_val_d = in_val_q;
        sh_reg_d = sh_reg_q;
        sh_val_d = sh_val_q;
        cnt_d    = cnt_q;
        if (adv) begin
            // Prefetched word has priority; otherwise the inbound word bypasses straight into the shift stage.
            // sh_reg only updates when a word is actually loaded so o_dat stays quiet while idle.
            if (in_val_q) begin
                sh_reg_d = in_reg_q;
            end else if (i_val) begin
                sh_reg_d = i_dat;
            end
            sh_val_d = in_val_q | i_val;
            cnt_d    = '0;
            in_val_d = 1'b0;
        end else begin
            in_val_d = in_val_q | i_val;
            if (!in_val_q) begin
                in_reg_d = i_dat;
            end
            if (sh_val_q && o_rdy) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef DS_SERIALIZER_MSB_FIRST_EN
    assign sel = CNT_LAST - cnt_q;
`else
    assign sel = cnt_q;
`endif

    always_comb begin
        o_dat = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (sel == CW'(k)) begin
                o_dat = sh_reg_q[k*WIDTH +: WIDTH];
            end
        end
    end

    assign i_rdy  = ~in_val_q;
    assign o_val  = sh_val_q;
    assign o_last = sh_val_q & at_last;

endmodule
